// File: rtl/lsu32.sv
// RV32I load/store unit: one outstanding access on a valid/ready memory port,
// returning extended load data or a store acknowledge to writeback.
module lsu32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_we,
    output logic [3:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state;
    logic        op_we;
    logic [2:0]  op_funct3;
    logic [1:0]  op_off;

    logic        misaligned;
    logic        illegal;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;
    logic [31:0] byte_shift;
    logic [31:0] half_shift;
    logic [31:0] load_c;

    // Decode the incoming request so it can be validated and laned on the accept edge.
    always_comb begin
        misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
        illegal    = req_we ? (req_funct3 >= 3'd3)
                            : ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7));
        strb_c  = 4'b1111;
        wdata_c = req_wdata;
        case (req_funct3[1:0])
            2'd0: begin
                strb_c  = 4'b0001 << req_addr[1:0];
                wdata_c = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                strb_c  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!req_we) begin
            strb_c = 4'b0000;
        end
    end

    always_comb begin
        byte_shift = mem_rdata >> {op_off, 3'b000};
        half_shift = mem_rdata >> {op_off[1], 4'b0000};
        case (op_funct3)
            3'd0:    load_c = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'd4:    load_c = {24'd0, byte_shift[7:0]};
            3'd1:    load_c = {{16{half_shift[15]}}, half_shift[15:0]};
            3'd5:    load_c = {16'd0, half_shift[15:0]};
            default: load_c = mem_rdata;
        endcase
    end

    // Rejected ops skip straight to DONE so no memory access is ever issued for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_err      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_wstrb     <= 4'b0000;
            mem_wdata     <= '0;
            op_we         <= 1'b0;
            op_funct3     <= 3'd0;
            op_off        <= 2'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_off    <= req_addr[1:0];
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        if (misaligned || illegal) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_we        <= req_we;
                            mem_wstrb     <= strb_c;
                            mem_wdata     <= wdata_c;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= op_we ? 32'd0 : load_c;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu32.sv
// Directed self-checking bench for lsu32: hand-computed loads, stores,
// error paths, request stalls and asynchronous reset mid-transaction.
module tb_lsu32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int resp_pulses = 0;
    int memreq_cycles = 0;

    always #5 clk = ~clk;

    lsu32 #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    always @(negedge clk) begin
        if (resp_valid) resp_pulses++;
        if (mem_req_valid) memreq_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic waitCycle;
        @(posedge clk);
        #1;
    endtask

    // Present one op and leave the bench one cycle after the accept edge.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            waitCycle;
            n++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", 32'd0, 32'd1);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        waitCycle;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'd7;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
    endtask

    task automatic doMemOp(input string tag, input int stall, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_strb,
                           input logic [31:0] e_wdata, input logic [31:0] e_rdata);
        int p0;
        p0 = resp_pulses;
        checkOutput({tag, "_mreqv"}, {31'd0, mem_req_valid}, 32'd1);
        checkOutput({tag, "_maddr"}, mem_addr, e_addr);
        checkOutput({tag, "_mwe"}, {31'd0, mem_we}, {31'd0, e_we});
        checkOutput({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, e_strb});
        if (e_we) checkOutput({tag, "_mwdata"}, mem_wdata, e_wdata);
        for (int i = 0; i < stall; i++) begin
            waitCycle;
            checkOutput({tag, "_stall_mreqv"}, {31'd0, mem_req_valid}, 32'd1);
            checkOutput({tag, "_stall_maddr"}, mem_addr, e_addr);
        end
        mem_req_ready = 1'b1;
        waitCycle;
        mem_req_ready = 1'b0;
        checkOutput({tag, "_mreqv_drop"}, {31'd0, mem_req_valid}, 32'd0);
        checkOutput({tag, "_early_resp"}, {31'd0, resp_valid}, 32'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = rdata;
        waitCycle;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'hA5A5_A5A5;
        checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, e_rdata);
        checkOutput({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        waitCycle;
        checkOutput({tag, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        checkOutput({tag, "_pulses"}, resp_pulses - p0, 32'd1);
    endtask

    task automatic doErrOp(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int p0;
        int m0;
        p0 = resp_pulses;
        m0 = memreq_cycles;
        applyStimulus(we, f3, addr, 32'hCAFE_F00D);
        checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        checkOutput({tag, "_resp_err"}, {31'd0, resp_err}, 32'd1);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        checkOutput({tag, "_mreqv"}, {31'd0, mem_req_valid}, 32'd0);
        waitCycle;
        checkOutput({tag, "_resp_drop"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        checkOutput({tag, "_pulses"}, resp_pulses - p0, 32'd1);
        checkOutput({tag, "_no_memreq"}, memreq_cycles - m0, 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mreqv"}, {31'd0, mem_req_valid}, 32'd0);
        checkOutput({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        checkOutput({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        checkOutput({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
        checkOutput({tag, "_maddr"}, mem_addr, 32'd0);
        checkOutput({tag, "_mwe"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        checkOutput({tag, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int p0;
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'd0;
        req_wdata      = 32'd0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'd0;
        #1;
        checkResetOutputs("por");
        #12 rst_n = 1'b1;
        waitCycle;
        checkOutput("por_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus(1'b0, 3'd0, 32'h0000_1003, 32'd0);
        doMemOp("lb", 0, 32'h8011_2233, 32'h0000_1000, 1'b0, 4'b0000, 32'd0, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'd4, 32'h0000_1003, 32'd0);
        doMemOp("lbu", 0, 32'h8011_2233, 32'h0000_1000, 1'b0, 4'b0000, 32'd0, 32'h0000_0080);

        applyStimulus(1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD);
        doMemOp("sh", 0, 32'hDEAD_BEEF, 32'h0000_2000, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'd0);
        applyStimulus(1'b1, 3'd0, 32'h0000_6001, 32'h1234_565A);
        doMemOp("sb", 1, 32'hDEAD_BEEF, 32'h0000_6000, 1'b1, 4'b0010, 32'h5A5A_5A5A, 32'd0);

        doErrOp("lw_mis", 1'b0, 3'd2, 32'h0000_3001);
        doErrOp("sbu_ill", 1'b1, 3'd4, 32'h0000_3000);
        doErrOp("lh_mis", 1'b0, 3'd1, 32'h0000_3003);

        applyStimulus(1'b0, 3'd5, 32'h0000_4002, 32'd0);
        doMemOp("lhu", 3, 32'hBEEF_0000, 32'h0000_4000, 1'b0, 4'b0000, 32'd0, 32'h0000_BEEF);
        applyStimulus(1'b0, 3'd1, 32'h0000_4002, 32'd0);
        doMemOp("lh", 0, 32'hBEEF_0000, 32'h0000_4000, 1'b0, 4'b0000, 32'd0, 32'hFFFF_BEEF);

        // Reset while waiting for memory data, with a stray response afterwards.
        p0 = resp_pulses;
        applyStimulus(1'b0, 3'd2, 32'h0000_7000, 32'd0);
        mem_req_ready = 1'b1;
        waitCycle;
        mem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_wait");
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h1111_2222;
        waitCycle;
        waitCycle;
        #3 rst_n = 1'b1;
        waitCycle;
        waitCycle;
        mem_resp_valid = 1'b0;
        checkOutput("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_wait_no_resp", resp_pulses - p0, 32'd0);

        // Reset while a store request is on the memory port.
        applyStimulus(1'b1, 3'd2, 32'h0000_7004, 32'h7777_7777);
        checkOutput("rst_req_pre_mreqv", {31'd0, mem_req_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_req");
        waitCycle;
        #3 rst_n = 1'b1;
        waitCycle;
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);

        applyStimulus(1'b1, 3'd2, 32'h0000_5000, 32'h1234_5678);
        doMemOp("sw1", 0, 32'h0, 32'h0000_5000, 1'b1, 4'b1111, 32'h1234_5678, 32'd0);
        applyStimulus(1'b1, 3'd2, 32'h0000_5000, 32'h1234_5678);
        doMemOp("sw2", 0, 32'h0, 32'h0000_5000, 1'b1, 4'b1111, 32'h1234_5678, 32'd0);
        applyStimulus(1'b0, 3'd2, 32'h0000_5000, 32'd0);
        doMemOp("lw", 0, 32'h1234_5678, 32'h0000_5000, 1'b0, 4'b0000, 32'd0, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
